data_mem_ctrl: RTL and testbench

Multi-cycle data-memory access controller sitting at the MEM stage, on the receiving end of the main decoder's MemRead/MemWrite strobes. It turns those strobes into a valid/ready request on the data-memory bus, collects the read response, aligns and sign-extends loaded data, and stalls the pipeline until the access completes. Writes complete on bus acceptance; reads complete on response.

---
 rtl/data_mem_ctrl_pkg.sv | 56 +++++
 rtl/data_mem_ctrl_if.sv | 29 ++
 rtl/data_mem_ctrl_load_extender.sv | 43 ++++
 rtl/data_mem_ctrl.sv | 138 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the data-memory access controller:
//   - state_e       : controller FSM states (IDLE, REQ, WAIT, DONE)
//   - F3_*          : Funct3 access size/sign encodings
//   - STRB_*        : base byte-enable patterns, shifted into lane position
//   - access_size() : folds Funct3 into B/H/W; undefined codes count as W
//   - is_misaligned : natural-alignment test used when MISALIGN_TRAP_EN is set
// ----------------------------------------------------------------------------
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

  function automatic size_e access_size(input logic [2:0] f3);
    size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    case (access_size(f3))
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = lo[0];
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl_if
// Data-memory bus between the MEM-stage controller and the memory.
//   request  : mem_req_valid/ready handshake with we, word address, data, strobes
//   response : mem_rsp_valid with mem_rsp_data (read data only)
// Modports: master = controller side, slave = memory side.
// ----------------------------------------------------------------------------
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [31:0]       mem_req_wdata;
  logic [3:0]        mem_req_wstrb;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/data_mem_ctrl_load_extender.sv
// ----------------------------------------------------------------------------
// load_extender (combinational)
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it according to Funct3.
//   word_i    : 32-bit word returned by the bus
//   addr_lo_i : byte offset addr[1:0] of the access
//   funct3_i  : access size/sign; undefined codes pass the word through
//   ext_o     : 32-bit extended load result
// Halfwords use addr[1] only, so an odd halfword offset reads the halfword
// containing it (that case only reaches here when misalign trapping is off).
// ----------------------------------------------------------------------------
module load_extender
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] ext_o
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = word_i[8*gi +: 8];
  end

  assign byte_sel = lane[addr_lo_i];
  assign half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    ext_o = word_i;
    case (funct3_i)
      F3_B:    ext_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    ext_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   ext_o = {24'd0, byte_sel};
      F3_HU:   ext_o = {16'd0, half_sel};
      default: ext_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl
// MEM-stage data-memory access controller. Converts MemRead/MemWrite strobes
// into a valid/ready bus request, waits for the read response, extends the
// loaded data and stalls the pipeline until the access completes.
//   clk, reset         : clock and synchronous active-high reset
//   MemRead/MemWrite   : access strobes, sampled in IDLE (store wins if both)
//   Funct3, Addr       : access size/sign and byte address
//   WrData             : store data
//   Stall              : combinational pipeline hold
//   RdData/RdValid     : extended load result, RdValid pulses in DONE
//   Misalign           : pulses in DONE for a misaligned access
//   bus                : data_mem_ctrl_if master modport
// Build option: define MISALIGN_TRAP_EN to detect misaligned H/HU/W accesses;
// they then skip the bus and report Misalign. Without it the offending low
// address bits are simply ignored for lane selection.
// ----------------------------------------------------------------------------
module data_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WrData,
  output logic              Stall,
  output logic [DATA_W-1:0] RdData,
  output logic              RdValid,
  output logic              Misalign,
  data_mem_ctrl_if.master   bus
);

  state_e            state_q, state_d;
  logic              we_q, mis_q;
  logic [2:0]        f3_q;
  logic [1:0]        lo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       rd_data_q;

  logic              accept;
  logic              accept_mis;
  logic [31:0]       st_wdata;
  logic [3:0]        st_wstrb;
  logic [31:0]       ext_data;

  assign accept = (state_q == S_IDLE) && (MemRead || MemWrite);

`ifdef MISALIGN_TRAP_EN
  assign accept_mis = is_misaligned(Funct3, Addr[1:0]);
  assign Misalign   = (state_q == S_DONE) && mis_q;
`else
  assign accept_mis = 1'b0;
  assign Misalign   = 1'b0;
`endif

  // Lane replication and strobes are formed from the live inputs and latched
  // on acceptance, so the bus fields never depend on the pipeline afterwards.
  always_comb begin
    st_wdata = WrData;
    st_wstrb = STRB_W;
    case (access_size(Funct3))
      SZ_B: begin
        st_wdata = {4{WrData[7:0]}};
        st_wstrb = STRB_B << Addr[1:0];
      end
      SZ_H: begin
        st_wdata = {2{WrData[15:0]}};
        st_wstrb = STRB_H << {Addr[1], 1'b0};
      end
      default: ;
    endcase
    if (!MemWrite) st_wstrb = STRB_NONE;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = accept_mis ? S_DONE : S_REQ;
      S_REQ:  if (bus.mem_req_ready) state_d = we_q ? S_DONE : S_WAIT;
      S_WAIT: if (bus.mem_rsp_valid) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  load_extender u_ext (
    .word_i    (bus.mem_rsp_data),
    .addr_lo_i (lo_q),
    .funct3_i  (f3_q),
    .ext_o     (ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      mis_q     <= 1'b0;
      f3_q      <= 3'd0;
      lo_q      <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      rd_data_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= MemWrite;
        mis_q   <= accept_mis;
        f3_q    <= Funct3;
        lo_q    <= Addr[1:0];
        addr_q  <= {Addr[ADDR_W-1:2], 2'b00};
        wdata_q <= st_wdata;
        wstrb_q <= st_wstrb;
      end
      if ((state_q == S_WAIT) && bus.mem_rsp_valid) rd_data_q <= ext_data;
    end
  end

  assign Stall = (state_q == S_REQ) || (state_q == S_WAIT) ||
                 ((state_q == S_IDLE) && (MemRead || MemWrite));

  assign bus.mem_req_valid = (state_q == S_REQ);
  assign bus.mem_req_we    = we_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wdata = wdata_q;
  assign bus.mem_req_wstrb = wstrb_q;

  assign RdData  = rd_data_q;
  assign RdValid = (state_q == S_DONE) && !we_q && !mis_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Directed and randomized accesses against a behavioural model of the
// load/store rules. Honours MISALIGN_TRAP_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr, WrData;
  logic        Stall, RdValid, Misalign;
  logic [31:0] RdData;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_rd = 32'd0;

  data_mem_ctrl_if #(.ADDR_W(32)) bus_if ();

  data_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Funct3   (Funct3),
    .Addr     (Addr),
    .WrData   (WrData),
    .Stall    (Stall),
    .RdData   (RdData),
    .RdValid  (RdValid),
    .Misalign (Misalign),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural load result: shift the addressed lane down, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input int unsigned a,
                                           input logic [2:0] f3);
    int unsigned v;
    case (f3)
      3'b000, 3'b100: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (f3 == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = (w >> (8 * (a & 2))) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_strb(input int unsigned a, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 4'(1 << (a % 4));
      3'b001, 3'b101: return 4'(3 << (a & 2));
      default:        return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return (d & 32'hFF) * 32'h0101_0101;
      3'b001, 3'b101: return (d & 32'hFFFF) * 32'h0001_0001;
      default:        return d;
    endcase
  endfunction

  function automatic logic ref_mis(input int unsigned a, input logic [2:0] f3);
`ifdef MISALIGN_TRAP_EN
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return (a % 2) != 0;
      default:        return (a % 4) != 0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  // One complete access from the IDLE cycle through DONE, ending in IDLE.
  task automatic access(input bit is_st, input bit both, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rsp, input int rdy_dly, input int rsp_dly);
    bit          mis;
    int          stall_cnt;
    int          exp_stall;
    logic [31:0] exp_rd;
    mis       = ref_mis(addr, f3);
    exp_rd    = (is_st || mis) ? model_rd : ref_load(rsp, addr, f3);
    exp_stall = mis ? 1 : (is_st ? rdy_dly + 2 : rdy_dly + rsp_dly + 3);
    stall_cnt = 0;

    chk("idle_stall", Stall, 0);
    MemWrite = is_st;
    MemRead  = !is_st || both;
    Funct3   = f3;
    Addr     = addr;
    WrData   = wd;
    #1;
    if (Stall) stall_cnt++;
    step();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Addr     = $urandom;
    WrData   = $urandom;
    if (!mis) begin
      for (int i = 0; i <= rdy_dly; i++) begin
        bus_if.mem_req_ready = (i == rdy_dly);
        #1;
        chk("req_valid", bus_if.mem_req_valid, 1);
        chk("req_we", bus_if.mem_req_we, is_st);
        chk("req_addr", bus_if.mem_req_addr, addr & ~32'd3);
        chk("req_wstrb", bus_if.mem_req_wstrb, is_st ? ref_strb(addr, f3) : 4'h0);
        if (is_st) chk("req_wdata", bus_if.mem_req_wdata, ref_wdata(wd, f3));
        if (Stall) stall_cnt++;
        step();
      end
      bus_if.mem_req_ready = 1'b0;
      if (!is_st) begin
        for (int i = 0; i <= rsp_dly; i++) begin
          bus_if.mem_rsp_valid = (i == rsp_dly);
          bus_if.mem_rsp_data  = (i == rsp_dly) ? rsp : $urandom;
          #1;
          chk("wait_valid_low", bus_if.mem_req_valid, 0);
          if (Stall) stall_cnt++;
          step();
        end
        bus_if.mem_rsp_valid = 1'b0;
      end
    end
    #1;
    chk("done_stall", Stall, 0);
    chk("done_valid_low", bus_if.mem_req_valid, 0);
    chk("done_rdvalid", RdValid, !is_st && !mis);
    chk("done_misalign", Misalign, mis);
    chk("done_rddata", RdData, exp_rd);
    chk("stall_cycles", stall_cnt, exp_stall);
    model_rd = exp_rd;
    $display("access st=%0b f3=%0d addr=%h mis=%0b rd=%h stall=%0d", is_st, f3, addr, mis,
             RdData, stall_cnt);
    step();
    chk("post_rdvalid", RdValid, 0);
    chk("post_misalign", Misalign, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"}, Stall, 0);
    chk({tag, "_valid"}, bus_if.mem_req_valid, 0);
    chk({tag, "_we"}, bus_if.mem_req_we, 0);
    chk({tag, "_addr"}, bus_if.mem_req_addr, 0);
    chk({tag, "_wdata"}, bus_if.mem_req_wdata, 0);
    chk({tag, "_wstrb"}, bus_if.mem_req_wstrb, 0);
    chk({tag, "_rddata"}, RdData, 0);
    chk({tag, "_rdvalid"}, RdValid, 0);
    chk({tag, "_misalign"}, Misalign, 0);
  endtask

  logic [2:0] ld_f3s [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b111};
  logic [2:0] st_f3s [3] = '{3'b000, 3'b001, 3'b010};

  initial begin
    reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0; Addr = 32'd0; WrData = 32'd0;
    bus_if.mem_req_ready = 1'b0;
    bus_if.mem_rsp_valid = 1'b0;
    bus_if.mem_rsp_data  = 32'd0;
    step(); step();
    reset = 1'b0;
    #1;
    chk_reset_outputs("reset");

    // Directed cases
    access(0, 0, 3'b000, 32'h103, 32'd0, 32'h80FF_1234, 0, 1);
    chk("lb_value", RdData, 32'hFFFF_FF80);
    access(1, 0, 3'b001, 32'h202, 32'h0000_BEEF, 32'd0, 3, 0);
    access(0, 0, 3'b101, 32'h10, 32'd0, 32'h0000_F00D, 0, 0);
    chk("lhu_value", RdData, 32'h0000_F00D);
    access(0, 0, 3'b010, 32'h10, 32'd0, 32'hDEAD_BEEF, 0, 0);
    chk("lw_value", RdData, 32'hDEAD_BEEF);
    access(1, 1, 3'b010, 32'h0C, 32'h1234_5678, 32'd0, 0, 0);
    access(0, 0, 3'b010, 32'h06, 32'd0, 32'hCAFE_F00D, 1, 0);

    // Reset while waiting for a load response; the late response is dropped.
    access(1, 0, 3'b010, 32'h44, 32'hA5A5_A5A5, 32'd0, 0, 0);
    MemRead = 1'b1; Funct3 = 3'b010; Addr = 32'h40;
    step();
    MemRead = 1'b0;
    bus_if.mem_req_ready = 1'b1;
    step();
    bus_if.mem_req_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    bus_if.mem_rsp_valid = 1'b1;
    bus_if.mem_rsp_data  = 32'h1357_9BDF;
    step();
    bus_if.mem_rsp_valid = 1'b0;
    chk_reset_outputs("late_rsp");
    step();
    chk_reset_outputs("late_rsp2");
    model_rd = 32'd0;
    $display("reset in WAIT: outputs at reset values, late response dropped");

    // Randomized accesses
    for (int n = 0; n < 60; n++) begin
      bit st;
      st = $urandom_range(0, 1);
      if (st)
        access(1, $urandom_range(0, 1), st_f3s[$urandom_range(0, 2)], $urandom_range(0, 16'hFFFF),
               $urandom, 32'd0, $urandom_range(0, 3), 0);
      else
        access(0, 0, ld_f3s[$urandom_range(0, 6)], $urandom_range(0, 16'hFFFF), 32'd0,
               $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
